ex_stage_md: RTL

- Parametrised execute stage for the MIPS pipeline, sitting between ID/EX and MEM.
- Adds an iterative unsigned multiply/divide unit with HI/LO registers. The stage stalls upstream while that unit is busy.
- Adds pipeline freeze and flush, configurable datapath width and explicit valid tracking.
- ALU ops arrive pre-decoded on ex_op; forwarding muxes and the EX/MEM register are built in.

---
 rtl/ex_stage_md.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_md.sv
// MIPS execute stage: forwarding muxes, ALU, iterative unsigned multiply/divide with HI/LO,
// and the EX/MEM pipeline register with freeze, flush and valid tracking.
//
// state   | meaning
// IDLE    | no mul/div in flight; a valid MULTU/DIVU issues from here
// BUSY    | one shift-add / restoring-divide iteration per cycle, count down to 1
// DONE    | result ready; HI/LO written and the instruction leaves EX this cycle
module ex_stage_md #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pstop_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_op_i,
  input  logic              alu_src_b_i,
  input  logic              dst_sel_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [1:0]        rs_fwd_sel_i,
  input  logic [1:0]        rt_fwd_sel_i,
  input  logic [XLEN-1:0]   mem_fwd_i,
  input  logic [XLEN-1:0]   wb_fwd_i,
  output logic              ex_stall_o,
  output logic [REG_AW-1:0] ex_dst_reg_o,
  output logic              md_busy_o,
  output logic              EX_MEM_valid,
  output logic              EX_MEM_reg_write,
  output logic              EX_MEM_mem_to_reg,
  output logic              EX_MEM_mem_read,
  output logic              EX_MEM_mem_write,
  output logic [XLEN-1:0]   EX_MEM_alu_result,
  output logic [XLEN-1:0]   EX_MEM_b_value,
  output logic [REG_AW-1:0] EX_MEM_dst_reg
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8, OP_SRA = 4'd9, OP_MULTU = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t       md_state;
  logic [CW-1:0]   md_count;
  logic [XLEN-1:0] md_hi, md_lo, md_b;
  logic            md_div;
  logic [XLEN-1:0] hi_q, lo_q;

  logic [XLEN-1:0] op_a, bval, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            md_issue;

  always_comb begin
    case (rs_fwd_sel_i)
      2'd0:    op_a = a_i;
      2'd1:    op_a = mem_fwd_i;
      2'd2:    op_a = wb_fwd_i;
      default: op_a = '0;
    endcase
    case (rt_fwd_sel_i)
      2'd0:    bval = b_i;
      2'd1:    bval = mem_fwd_i;
      2'd2:    bval = wb_fwd_i;
      default: bval = '0;
    endcase
  end

  assign op_b         = alu_src_b_i ? imm_i : bval;
  assign shamt        = op_b[SHW-1:0];
  assign ex_dst_reg_o = dst_sel_i ? rd_i : rt_i;

  always_comb begin
    alu_res = '0;
    case (ex_op_i)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_NOR:  alu_res = ~(op_a | op_b);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Multiply: {md_hi, md_lo} is the shifting product/multiplier pair.
  // Divide: md_hi is the partial remainder, md_lo shifts dividend out and quotient in.
  logic [XLEN:0]   mul_sum, div_trial;
  logic            div_take;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  assign mul_sum   = {1'b0, md_hi} + {1'b0, (md_lo[0] ? md_b : {XLEN{1'b0}})};
  assign div_trial = {md_hi, md_lo[XLEN-1]} - {1'b0, md_b};
  // A zero divisor always "subtracts", giving an all-ones quotient and remainder = dividend.
  assign div_take  = !div_trial[XLEN] || (md_b == '0);

  always_comb begin
    if (md_div) begin
      hi_nxt = div_take ? div_trial[XLEN-1:0] : {md_hi[XLEN-2:0], md_lo[XLEN-1]};
      lo_nxt = {md_lo[XLEN-2:0], div_take};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], md_lo[XLEN-1:1]};
    end
  end

  assign md_issue   = (md_state == MD_IDLE) && ex_valid_i &&
                      (ex_op_i == OP_MULTU || ex_op_i == OP_DIVU);
  assign ex_stall_o = !rst && !flush_i && ((md_state == MD_BUSY) || md_issue);
  assign md_busy_o  = (md_state != MD_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      md_state <= MD_IDLE;
      md_count <= '0;
      md_hi    <= '0;
      md_lo    <= '0;
      md_b     <= '0;
      md_div   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (!pstop_i) begin
      if (flush_i) begin
        md_state <= MD_IDLE;
      end else begin
        case (md_state)
          MD_IDLE: if (md_issue) begin
            md_state <= MD_BUSY;
            md_count <= CW'(XLEN);
            md_hi    <= '0;
            md_lo    <= op_a;
            md_b     <= op_b;
            md_div   <= (ex_op_i == OP_DIVU);
          end
          MD_BUSY: begin
            md_hi    <= hi_nxt;
            md_lo    <= lo_nxt;
            md_count <= md_count - 1'b1;
            if (md_count == CW'(1)) md_state <= MD_DONE;
          end
          MD_DONE: begin
            hi_q     <= md_hi;
            lo_q     <= md_lo;
            md_state <= MD_IDLE;
          end
          default: md_state <= MD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      EX_MEM_valid      <= 1'b0;
      EX_MEM_reg_write  <= 1'b0;
      EX_MEM_mem_to_reg <= 1'b0;
      EX_MEM_mem_read   <= 1'b0;
      EX_MEM_mem_write  <= 1'b0;
      EX_MEM_alu_result <= '0;
      EX_MEM_b_value    <= '0;
      EX_MEM_dst_reg    <= '0;
    end else if (!pstop_i) begin
      // A stalled cycle sends a bubble so MEM/WB never see the mul/div instruction twice.
      if (flush_i || ex_stall_o) begin
        EX_MEM_valid      <= 1'b0;
        EX_MEM_reg_write  <= 1'b0;
        EX_MEM_mem_to_reg <= 1'b0;
        EX_MEM_mem_read   <= 1'b0;
        EX_MEM_mem_write  <= 1'b0;
        EX_MEM_alu_result <= '0;
        EX_MEM_b_value    <= '0;
        EX_MEM_dst_reg    <= '0;
      end else begin
        EX_MEM_valid      <= ex_valid_i;
        EX_MEM_reg_write  <= reg_write_i;
        EX_MEM_mem_to_reg <= mem_to_reg_i;
        EX_MEM_mem_read   <= mem_read_i;
        EX_MEM_mem_write  <= mem_write_i;
        EX_MEM_alu_result <= alu_res;
        EX_MEM_b_value    <= bval;
        EX_MEM_dst_reg    <= ex_dst_reg_o;
      end
    end
  end
endmodule
